// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF    = 5;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned BURST_MAX_DEF = 4;
  localparam int unsigned BCNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Read return tag: which port issued a read still in flight.
  typedef struct packed {
    logic vld;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Read-return routing: tracks reads through RAM command and data latency
// and steers ram_rd_data to the issuing port as a one-cycle valid pulse.
module ram_arb_rd_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_issue_i,
  input  logic              rd_port_i,
  input  logic [DATA_W-1:0] ram_rd_data_i,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);

  rd_tag_t           s1_q, s2_q;
  logic              rv0_q, rv1_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;

  // Stage 1 aligns with the registered RAM command, stage 2 with RAM data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q  <= '0;
      s2_q  <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      s1_q.vld  <= rd_issue_i;
      s1_q.port <= rd_port_i;
      s2_q      <= s1_q;
      rv0_q     <= s2_q.vld && !s2_q.port;
      rv1_q     <= s2_q.vld && s2_q.port;
      if (s2_q.vld && !s2_q.port) rd0_q <= ram_rd_data_i;
      if (s2_q.vld && s2_q.port)  rd1_q <= ram_rd_data_i;
    end
  end

  assign rvalid0_o = rv0_q;
  assign rvalid1_o = rv1_q;
  assign rdata0_o  = rd0_q;
  assign rdata1_o  = rd1_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter onto a single 1-cycle-latency RAM with burst-limited
// ownership, same-cycle grants and registered RAM command outputs.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(BURST_MAX);
  localparam logic [BCNT_W-1:0] BCNT_SAT  = '1;

  arb_state_e        state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              last_q;
  logic              ram_en_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wd_q;

  logic              gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic [BCNT_W-1:0] bcnt_inc(input logic [BCNT_W-1:0] c);
    return (c == BCNT_SAT) ? c : c + 1'b1;
  endfunction

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    bcnt_d  = bcnt_q;
    if (sys_rst_n) begin
      unique case (state_q)
        IDLE: begin
          // On contention the port that did not own the RAM last goes first.
          if (req0 && (!req1 || last_q)) begin
            gnt0    = 1'b1;
            state_d = OWN0;
            bcnt_d  = BCNT_W'(1);
          end else if (req1) begin
            gnt1    = 1'b1;
            state_d = OWN1;
            bcnt_d  = BCNT_W'(1);
          end
        end
        OWN0: begin
          if (req0 && (bcnt_q < BURST_LIM || !req1)) begin
            gnt0   = 1'b1;
            bcnt_d = bcnt_inc(bcnt_q);
          end else if (req1) begin
            gnt1    = 1'b1;
            state_d = OWN1;
            bcnt_d  = BCNT_W'(1);
          end else begin
            state_d = IDLE;
            bcnt_d  = '0;
          end
        end
        OWN1: begin
          if (req1 && (bcnt_q < BURST_LIM || !req0)) begin
            gnt1   = 1'b1;
            bcnt_d = bcnt_inc(bcnt_q);
          end else if (req0) begin
            gnt0    = 1'b1;
            state_d = OWN0;
            bcnt_d  = BCNT_W'(1);
          end else begin
            state_d = IDLE;
            bcnt_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          bcnt_d  = '0;
        end
      endcase
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      last_q     <= 1'b1;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_wd_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      if (gnt_any) begin
        last_q     <= gnt1;
        ram_en_q   <= 1'b1;
        ram_we_q   <= sel_we;
        ram_addr_q <= sel_addr;
        ram_wd_q   <= sel_wdata;
      end else begin
        ram_en_q <= 1'b0;
        ram_we_q <= 1'b0;
      end
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_data = ram_wd_q;

  ram_arb_rd_pipe #(
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk_i         (sys_clk),
    .rst_ni        (sys_rst_n),
    .rd_issue_i    (gnt_any && !sel_we),
    .rd_port_i     (gnt1),
    .ram_rd_data_i (ram_rd_data),
    .rvalid0_o     (rvalid0),
    .rvalid1_o     (rvalid1),
    .rdata0_o      (rdata0),
    .rdata1_o      (rdata1)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed sequences, a grant-pattern table and a
// randomized run against a transaction-level reference model.
module tb_ram_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int          BM = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we;
  logic [DW-1:0] rdata0, rdata1, ram_wr_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd_data = '0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural single-port RAM with one cycle of read latency.
  logic [DW-1:0] mem [0:31];
  always @(posedge sys_clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wr_data;
      else        ram_rd_data   <= mem[ram_addr];
    end
  end

  logic [DW-1:0] ref_mem [0:31];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic r0, r1;
    logic eg0, eg1, een;
  } vec_t;
  vec_t tbl[21];

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } ret_t;
  ret_t rq[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic r1, input logic w0, input logic w1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  task automatic idle_in();
    drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic to_sample();
    @(negedge sys_clk);
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    idle_in();
    next_cycle();
    next_cycle();
    sys_rst_n = 1'b1;
  endtask

  // Random-phase model state: owner -1 means nobody holds the RAM.
  int            owner, run, last_own, g;
  logic [1:0]    p_req, p_we;
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_dat  [2];
  logic          exp_en, exp_we, exp_v0, exp_v1;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd, exp_rd0, exp_rd1;
  logic [8:0]    both_g1;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    // Both ports requesting from reset: four grants each, then back to port 0.
    both_g1 = 9'b0_1111_0000;
    for (int i = 0; i < 21; i++) begin
      tbl[i].r0  = (i < 19);
      tbl[i].r1  = (i < 9);
      tbl[i].eg1 = (i < 9) ? both_g1[i] : 1'b0;
      tbl[i].eg0 = (i < 19) && !tbl[i].eg1;
      tbl[i].een = (i > 0) && (i < 20);
    end

    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    drv(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 5'd9, 8'hFF, 8'hEE);
    next_cycle();
    to_sample();
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_ram_en", ram_en, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chkw("rst_ram_addr", 32'(ram_addr), 32'd0);
    chkw("rst_ram_wd", 32'(ram_wr_data), 32'd0);
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk1("rst_rvalid1", rvalid1, 1'b0);
    chkw("rst_rdata0", 32'(rdata0), 32'd0);
    chkw("rst_rdata1", 32'(rdata1), 32'd0);
    next_cycle();
    do_reset();

    // Single write from port 0.
    drv(1'b1, 1'b0, 1'b1, 1'b0, 5'd3, '0, 8'h5A, '0);
    to_sample();
    chk1("wr_gnt0", gnt0, 1'b1);
    chk1("wr_gnt1", gnt1, 1'b0);
    ref_mem[3] = 8'h5A;
    next_cycle();
    idle_in();
    to_sample();
    chk1("wr_ram_en", ram_en, 1'b1);
    chk1("wr_ram_we", ram_we, 1'b1);
    chkw("wr_ram_addr", 32'(ram_addr), 32'd3);
    chkw("wr_ram_wd", 32'(ram_wr_data), 32'h5A);
    chk1("wr_gnt0_drop", gnt0, 1'b0);
    next_cycle();
    to_sample();
    chk1("wr_ram_en_off", ram_en, 1'b0);
    next_cycle();

    // Port 1 reads back the written word; return three cycles after grant.
    drv(1'b0, 1'b1, 1'b0, 1'b0, '0, 5'd3, '0, '0);
    to_sample();
    chk1("rd_gnt1", gnt1, 1'b1);
    chk1("rd_gnt0", gnt0, 1'b0);
    next_cycle();
    idle_in();
    for (int k = 1; k <= 3; k++) begin
      to_sample();
      chk1("rd_rvalid0", rvalid0, 1'b0);
      if (k < 3) chk1("rd_rvalid1_early", rvalid1, 1'b0);
      else begin
        chk1("rd_rvalid1", rvalid1, 1'b1);
        chkw("rd_rdata1", 32'(rdata1), 32'h5A);
      end
      next_cycle();
    end

    // Preload 0x11 / 0x22, then back-to-back alternating reads.
    drv(1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 8'h11, 8'h22);
    to_sample();
    chk1("pre_gnt0", gnt0, 1'b1);
    chk1("pre_gnt1_blocked", gnt1, 1'b0);
    ref_mem[1] = 8'h11;
    next_cycle();
    drv(1'b0, 1'b1, 1'b0, 1'b1, '0, 5'd2, '0, 8'h22);
    to_sample();
    chk1("pre_gnt1", gnt1, 1'b1);
    ref_mem[2] = 8'h22;
    next_cycle();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, '0, '0, '0);
    to_sample();
    chk1("alt_gnt0", gnt0, 1'b1);
    next_cycle();
    drv(1'b0, 1'b1, 1'b0, 1'b0, '0, 5'd2, '0, '0);
    to_sample();
    chk1("alt_gnt1", gnt1, 1'b1);
    next_cycle();
    idle_in();
    to_sample();
    chk1("alt_rv0_early", rvalid0, 1'b0);
    chk1("alt_rv1_early", rvalid1, 1'b0);
    next_cycle();
    to_sample();
    chk1("alt_rv0", rvalid0, 1'b1);
    chkw("alt_rd0", 32'(rdata0), 32'h11);
    chk1("alt_rv1_wait", rvalid1, 1'b0);
    next_cycle();
    to_sample();
    chk1("alt_rv1", rvalid1, 1'b1);
    chkw("alt_rd1", 32'(rdata1), 32'h22);
    chk1("alt_rv0_pulse", rvalid0, 1'b0);
    chkw("alt_rd0_hold", 32'(rdata0), 32'h11);
    next_cycle();

    // Grant pattern table: contention bursts, long solo burst, release to idle.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drv(tbl[i].r0, tbl[i].r1, 1'b0, 1'b0, AW'(i), AW'(i), '0, '0);
      to_sample();
      chk1($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].eg0);
      chk1($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].eg1);
      chk1($sformatf("tbl%0d_ram_en", i), ram_en, tbl[i].een);
      next_cycle();
    end

    // Reset one cycle after a read grant kills the return.
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, '0, '0, '0);
    to_sample();
    chk1("rr_gnt0", gnt0, 1'b1);
    next_cycle();
    sys_rst_n = 1'b0;
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, '0, '0);
    to_sample();
    chk1("rr_gnt0_in_rst", gnt0, 1'b0);
    chk1("rr_gnt1_in_rst", gnt1, 1'b0);
    next_cycle();
    sys_rst_n = 1'b1;
    idle_in();
    for (int k = 0; k < 3; k++) begin
      to_sample();
      chk1("rr_rvalid0", rvalid0, 1'b0);
      chk1("rr_rvalid1", rvalid1, 1'b0);
      chkw("rr_rdata0", 32'(rdata0), 32'd0);
      chkw("rr_rdata1", 32'(rdata1), 32'd0);
      chk1("rr_ram_en", ram_en, 1'b0);
      chkw("rr_ram_addr", 32'(ram_addr), 32'd0);
      next_cycle();
    end

    // Randomized traffic against the reference model.
    owner = -1; run = 0; last_own = 1;
    p_req = '0; p_we = '0;
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    exp_rd0 = '0; exp_rd1 = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && $urandom_range(0, 99) < 55) begin
          p_req[p]  = 1'b1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = AW'($urandom_range(0, 7));
          p_dat[p]  = DW'($urandom_range(0, 255));
        end
      end
      drv(p_req[0], p_req[1], p_we[0], p_we[1], p_addr[0], p_addr[1], p_dat[0], p_dat[1]);

      if (owner < 0) begin
        if (p_req[0] && p_req[1]) g = 1 - last_own;
        else if (p_req[0])        g = 0;
        else if (p_req[1])        g = 1;
        else                      g = -1;
      end else if (p_req[owner] && (run < BM || !p_req[1-owner])) g = owner;
      else if (p_req[1-owner]) g = 1 - owner;
      else                     g = -1;

      exp_v0 = 1'b0;
      exp_v1 = 1'b0;
      if (rq.size() > 0 && rq[0].due == c) begin
        if (rq[0].port == 0) begin exp_v0 = 1'b1; exp_rd0 = rq[0].data; end
        else                 begin exp_v1 = 1'b1; exp_rd1 = rq[0].data; end
        void'(rq.pop_front());
      end

      to_sample();
      chk1("rnd_gnt0", gnt0, g == 0);
      chk1("rnd_gnt1", gnt1, g == 1);
      chk1("rnd_ram_en", ram_en, exp_en);
      chk1("rnd_ram_we", ram_we, exp_we);
      chkw("rnd_ram_addr", 32'(ram_addr), 32'(exp_addr));
      chkw("rnd_ram_wd", 32'(ram_wr_data), 32'(exp_wd));
      chk1("rnd_rvalid0", rvalid0, exp_v0);
      chk1("rnd_rvalid1", rvalid1, exp_v1);
      chkw("rnd_rdata0", 32'(rdata0), 32'(exp_rd0));
      chkw("rnd_rdata1", 32'(rdata1), 32'(exp_rd1));

      if (g >= 0) begin
        exp_en   = 1'b1;
        exp_we   = p_we[g];
        exp_addr = p_addr[g];
        exp_wd   = p_dat[g];
        if (p_we[g]) ref_mem[p_addr[g]] = p_dat[g];
        else         rq.push_back('{c + 3, g, ref_mem[p_addr[g]]});
        p_req[g] = 1'b0;
        run      = (g == owner) ? ((run < 15) ? run + 1 : 15) : 1;
        owner    = g;
        last_own = g;
      end else begin
        exp_en = 1'b0;
        exp_we = 1'b0;
        owner  = -1;
        run    = 0;
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width (32 words).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter BURST_MAX, default 4, maximum consecutive grants to one port while the other port is requesting; legal range 1..15.
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-006 req0 / req1  in  1  access request, port 0 / port 1.
REQ-007 we0 / we1  in  1  1 = write, 0 = read; valid while reqN = 1.
REQ-008 addr0 / addr1  in  ADDR_W  access address; valid while reqN = 1.
REQ-009 wdata0 / wdata1  in  DATA_W  write data; valid while reqN = 1 and weN = 1.
REQ-010 gnt0 / gnt1  out  1  combinational; accepts this cycle's command from port N.
REQ-011 rvalid0 / rvalid1  out  1  registered one-cycle pulse; read data for port N is on rdataN.
REQ-012 rdata0 / rdata1  out  DATA_W  registered read return data, port N.
REQ-013 ram_en / ram_we  out  1 / 1  registered RAM enable / write enable.
REQ-014 ram_addr / ram_wr_data  out  ADDR_W / DATA_W  registered RAM address / write data.
REQ-015 ram_rd_data  in  DATA_W  RAM read data, valid the cycle after the RAM samples a read (1-cycle RAM latency).

Function
REQ-016 The FSM SHALL have states IDLE, OWN0 and OWN1; at most one of gnt0/gnt1 is high per cycle.
REQ-017 A requester SHALL hold reqN/weN/addrN/wdataN stable until it sees gntN; each gntN cycle transfers exactly one command.
REQ-018 IDLE, one req high: grant that port in the same cycle, next state OWNn.
REQ-019 IDLE, both req high: grant the port not recorded as last owner, next state OWN of that port.
REQ-020 OWNn, reqn high and (burst count < BURST_MAX or other req low): grant n again, increment burst count (saturating at 15).
REQ-021 OWNn, other req high and (reqn low or burst count = BURST_MAX): grant other port in the same cycle (no bubble), next state OWN of that port, burst count = 1.
REQ-022 OWNn, both req low: no grant, next state IDLE, burst count = 0.
REQ-023 The last-owner register SHALL update on every grant to the granted port number.
REQ-024 On a grant in cycle T: ram_en = 1, ram_we = weN, ram_addr = addrN, ram_wr_data = wdataN, all registered at end of T.
REQ-025 On a cycle without grant: ram_en = 0 and ram_we = 0 at end of cycle; ram_addr and ram_wr_data hold.
REQ-026 Read latency: read granted in cycle T yields rvalidN = 1 with rdataN = ram_rd_data in cycle T+3; writes never produce rvalid.
REQ-027 A 2-stage read tag pipeline (valid + port id) SHALL route each return to the issuing port; back-to-back reads from alternating ports return in issue order, one per cycle.
REQ-028 rdataN SHALL hold its last value when rvalidN = 0.

Reset
REQ-029 With sys_rst_n = 0 at a rising edge: state IDLE, last owner = 1, burst count 0, ram_en 0, ram_we 0, ram_addr 0, ram_wr_data 0, rvalid0/1 0, rdata0/1 0, tag pipeline cleared.
REQ-030 gnt0/gnt1 SHALL be 0 while sys_rst_n = 0.
REQ-031 Reset mid-operation SHALL drop all in-flight reads (no rvalid after reset); a write already registered to the RAM is not cancelled.

Structure
REQ-032 Package ram_arb_pkg SHALL hold the state enumeration (IDLE/OWN0/OWN1) and default ADDR_W, DATA_W, BURST_MAX constants.
REQ-033 The read return tag pipeline SHALL be the sub-module ram_arb_rd_pipe; the FSM and RAM command registers stay in ram_arbiter.

Verification
REQ-034 Reset then req0 write addr 3 data 0x5A -> gnt0 same cycle; next cycle ram_en 1, ram_we 1, ram_addr 3, ram_wr_data 0x5A; following cycle ram_en 0.
REQ-035 After REQ-034, req1 read addr 3 granted cycle T -> rvalid1 = 1, rdata1 = 0x5A in T+3; rvalid0 stays 0.
REQ-036 req0 and req1 both high from IDLE after reset -> gnt0 first; both held continuously -> grant pattern 0,0,0,0,1,1,1,1,0 (BURST_MAX 4).
REQ-037 req0 alone held 10 cycles -> 10 consecutive gnt0, no switch; req0 drops with req1 low -> IDLE, ram_en 0 next cycle.
REQ-038 Alternating reads port0 addr 1 / port1 addr 2 (contents 0x11/0x22) -> returns 0x11 on port 0, 0x22 on port 1, consecutive cycles, correct routing.
REQ-039 sys_rst_n low one cycle after a read grant -> no rvalid on either port; all outputs at reset values.
